// File: rtl/spi_pkg.sv
// Shared types for the SPI transaction sequencer.
// Holds the sequencer state encoding and the byte width.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        ISSUE,
        WAIT,
        GAP,
        HOLD
    } xfer_state_t;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous first-word fall-through FIFO.
// Used for both the TX and the RX byte queues of the sequencer.
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO still takes the push.
    assign push_ok = push_i & (~full_o | pop_i);
    assign pop_ok  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Multi-byte SPI transaction sequencer in front of a byte-level SPI core.
// Owns slave select timing and moves bytes between host FIFOs and the core.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 8,
    parameter int DLY_W      = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tx_wr_i,
    input  logic [BYTE_W-1:0] tx_data_i,
    output logic              tx_full_o,
    input  logic              rx_rd_i,
    output logic [BYTE_W-1:0] rx_data_o,
    output logic              rx_empty_o,
    input  logic              go_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [DLY_W-1:0]  cs_dly_i,
    input  logic [DLY_W-1:0]  gap_i,
    output logic              busy_o,
    output logic              done_tick_o,
    output logic              rx_ovf_o,
    output logic              ss_n_o,
    output logic              core_start_o,
    output logic [BYTE_W-1:0] core_din_o,
    input  logic              core_ready_i,
    input  logic              core_done_tick_i,
    input  logic [BYTE_W-1:0] core_dout_i
);

    xfer_state_t       state_q, state_d;
    logic [LEN_W-1:0]  n_q, n_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DLY_W-1:0]  d_q, d_d;
    logic [DLY_W-1:0]  cs_dly_q, cs_dly_d;
    logic [DLY_W-1:0]  gap_q, gap_d;
    logic              ss_n_q, ss_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    logic              tx_empty;
    logic [BYTE_W-1:0] tx_head;
    logic              rx_full;
    logic              rx_push;

    assign core_start_o = (state_q == ISSUE) & core_ready_i & ~tx_empty;
    assign core_din_o   = tx_head;
    assign rx_push      = (state_q == WAIT) & core_done_tick_i;

    assign ss_n_o      = ss_n_q;
    assign busy_o      = busy_q;
    assign done_tick_o = done_q;
    assign rx_ovf_o    = ovf_q;

    spi_sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tx_wr_i),
        .din_i   (tx_data_i),
        .pop_i   (core_start_o),
        .dout_o  (tx_head),
        .full_o  (tx_full_o),
        .empty_o (tx_empty)
    );

    spi_sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rx_push),
        .din_i   (core_dout_i),
        .pop_i   (rx_rd_i),
        .dout_o  (rx_data_o),
        .full_o  (rx_full),
        .empty_o (rx_empty_o)
    );

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        len_d    = len_q;
        d_d      = d_q;
        cs_dly_d = cs_dly_q;
        gap_d    = gap_q;
        ss_n_d   = ss_n_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (go_i) begin
                    ovf_d    = 1'b0;
                    len_d    = len_i;
                    cs_dly_d = cs_dly_i;
                    gap_d    = gap_i;
                    if (len_i != '0) begin
                        state_d = CS_SETUP;
                        ss_n_d  = 1'b0;
                        busy_d  = 1'b1;
                        d_d     = '0;
                        n_d     = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            CS_SETUP: begin
                if (d_q == cs_dly_q) state_d = ISSUE;
                else                 d_d = d_q + 1'b1;
            end
            ISSUE: begin
                if (core_start_o) state_d = WAIT;
            end
            WAIT: begin
                if (core_done_tick_i) begin
                    // The RX FIFO still accepts the byte when the host pops this cycle.
                    if (rx_full & ~rx_rd_i) ovf_d = 1'b1;
                    d_d = '0;
                    if (n_q == len_q - LEN_W'(1)) begin
                        state_d = HOLD;
                    end else begin
                        n_d     = n_q + 1'b1;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (d_q == gap_q) state_d = ISSUE;
                else              d_d = d_q + 1'b1;
            end
            HOLD: begin
                if (d_q == cs_dly_q) begin
                    state_d = IDLE;
                    ss_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    d_d = d_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            n_q      <= '0;
            len_q    <= '0;
            d_q      <= '0;
            cs_dly_q <= '0;
            gap_q    <= '0;
            ss_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            len_q    <= len_d;
            d_q      <= d_d;
            cs_dly_q <= cs_dly_d;
            gap_q    <= gap_d;
            ss_n_q   <= ss_n_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule
